matrix_4x4_stream_bridge: RTL and testbench
===========================================

Name: matrix_4x4_stream_bridge

Overview:
Host-side initiator/consumer for the 4x4 matrix compute engine. It accepts operand matrices A and B as a serial W-bit word stream and assembles them into the column-packed operand buses. It issues one job to the compute engine over its valid/ready handshake and holds the operands stable while the engine runs. It then captures the result columns and streams the 16 result words back out serially.

Parameters:
W, 12, element width in bits; matches the compute engine element width.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  input word valid
in_ready  out  1  bridge can accept an input word
in_data  in  W  operand element
in_last  in  1  marks the final word of a 32-word job
out_valid  out  1  result word valid
out_ready  in  1  downstream accepts the result word
out_data  out  W  result element
out_last  out  1  marks the 16th result word of a job
err  out  1  sticky framing error flag
mm_valid  out  1  to engine valid_in
mm_ready  in  1  from engine ready_out
mm_ready_res  out  1  to engine ready_in
mm_valid_res  in  1  from engine valid_out
aC1..aC4, bC1..bC4  out  4*W each  operand columns; element [i] of xCj is row i, column j
cC1..cC4  in  4*W each  result columns, same packing as the operand columns

Behaviour:
- Reset (rst_n=0 at a clock edge): state=LOAD, word counter=0, in_ready=1, out_valid=0, out_last=0, out_data=0, err=0, mm_valid=0, mm_ready_res=0, all operand registers=0. Reset takes effect at any point, including mid-job. The bridge does not reset the engine.
- Input handshake:
  - A transfer occurs when in_valid & in_ready.
  - Words 0..15 fill A and words 16..31 fill B, column-major. For word k within a matrix: column = k/4 + 1, row = k%4.
- Framing:
  - in_last on word 31 is the expected case.
  - in_last on any word other than 31 sets err and discards the partial job. The counter returns to 0, state stays LOAD, and the operand registers keep their old values.
  - Word 31 accepted without in_last sets err, but the job proceeds normally.
- States:
  - LOAD: in_ready=1. On acceptance of word 31 the counter goes to 0 and the next state is ISSUE.
  - ISSUE: in_ready=0 and mm_valid=1. mm_valid is asserted in the cycle after word 31 is accepted. On mm_valid & mm_ready: mm_valid=0 next cycle, next state WAIT_RES. mm_valid stays high until the transfer occurs.
  - WAIT_RES: mm_ready_res=1. On mm_valid_res & mm_ready_res:
    - cC1..cC4 are captured into the result buffer.
    - mm_ready_res=0 next cycle; next state DRAIN.
    - mm_valid_res is ignored in all other states. The engine holds valid for one cycle after the handshake; that cycle must not be re-captured.
  - DRAIN: 16 result words are presented in the order cC1[0..3], cC2[0..3], cC3[0..3], cC4[0..3].
    - out_valid=1 and out_data/out_last hold stable while out_ready=0.
    - The index advances on out_valid & out_ready.
    - out_last=1 only with word 15. After word 15 is accepted: out_valid=0, next state LOAD, in_ready=1 next cycle.
- Operand stability: aC*/bC* are registered outputs. They change only on accepted LOAD words and must hold from ISSUE through WAIT_RES, because the engine reads them combinationally for its full compute duration.
- No overlap: a new job is never loaded while a job is in ISSUE, WAIT_RES or DRAIN.
- Arithmetic: none. Results pass through unchanged at W bits; truncation is the engine's responsibility.
- Latency:
  - Word 31 accepted to mm_valid high: 1 cycle.
  - Result capture to first out_valid: 1 cycle.
  - With continuous out_ready, the 16 result words take 16 consecutive cycles.
- err clears only on reset.

Test Plan:
- Identity A (diagonal 1, others 0), B words 1..16, engine model, out_ready=1 -> 16 outputs 1..16 in order; out_last only on 16th; err=0.
- A all 2, B all 3 -> every output 24 (4*2*3); operand buses stable from ISSUE until result capture, checked every cycle.
- out_ready toggling 1/0 each cycle during DRAIN -> out_data held while stalled; exactly 16 transfers; in_ready stays 0 until the last transfer, then goes to 1 the next cycle.
- in_last on word 5 -> err=1; next full 32-word job processes correctly; err remains 1.
- mm_ready held 0 for 10 cycles in ISSUE -> mm_valid stays 1 throughout; exactly one job issued; the extra mm_valid_res cycle after capture produces no second capture.
- rst_n=0 during DRAIN after 7 words -> next cycle out_valid=0, in_ready=1, err=0; the following job runs correctly.

Source files
------------

// File: rtl/matrix_4x4_stream_bridge.sv
// Host-side bridge for the 4x4 matrix engine: deserialises A/B operand words into
// column buses, issues one job, captures the result columns and streams them back out.
module matrix_4x4_stream_bridge #(
  parameter int W = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic           err,
  output logic           mm_valid,
  input  logic           mm_ready,
  output logic           mm_ready_res,
  input  logic           mm_valid_res,
  output logic [4*W-1:0] aC1,
  output logic [4*W-1:0] aC2,
  output logic [4*W-1:0] aC3,
  output logic [4*W-1:0] aC4,
  output logic [4*W-1:0] bC1,
  output logic [4*W-1:0] bC2,
  output logic [4*W-1:0] bC3,
  output logic [4*W-1:0] bC4,
  input  logic [4*W-1:0] cC1,
  input  logic [4*W-1:0] cC2,
  input  logic [4*W-1:0] cC3,
  input  logic [4*W-1:0] cC4
);

  typedef enum logic [1:0] {LOAD, ISSUE, WAIT_RES, DRAIN} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [4:0]          r_cnt;
  logic [3:0]          r_idx;
  logic                r_err;
  logic [15:0][W-1:0]  r_a;
  logic [15:0][W-1:0]  r_b;
  logic [15:0][W-1:0]  r_res;
  logic                w_badLast;

  // in_last anywhere but word 31 aborts the partial job
  assign w_badLast = in_last & (r_cnt != 5'd31);

  // Element k of each array is column k/4, row k%4, so a 4-element slice is one column bus
  assign aC1 = r_a[3:0];
  assign aC2 = r_a[7:4];
  assign aC3 = r_a[11:8];
  assign aC4 = r_a[15:12];
  assign bC1 = r_b[3:0];
  assign bC2 = r_b[7:4];
  assign bC3 = r_b[11:8];
  assign bC4 = r_b[15:12];
  assign err = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    in_ready     = 1'b0;
    mm_valid     = 1'b0;
    mm_ready_res = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_data     = '0;
    case (r_state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && !w_badLast && (r_cnt == 5'd31)) w_nextState = ISSUE;
      end
      ISSUE: begin
        mm_valid = 1'b1;
        if (mm_ready) w_nextState = WAIT_RES;
      end
      WAIT_RES: begin
        mm_ready_res = 1'b1;
        if (mm_valid_res) w_nextState = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = r_res[r_idx];
        out_last  = (r_idx == 4'd15);
        if (out_ready && (r_idx == 4'd15)) w_nextState = LOAD;
      end
      default: w_nextState = LOAD;
    endcase
  end

  // Operands only move in LOAD, so they stay frozen while the engine computes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_err <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (in_valid) begin
            if (w_badLast) begin
              r_err <= 1'b1;
              r_cnt <= '0;
            end else begin
              if (r_cnt[4]) r_b[r_cnt[3:0]] <= in_data;
              else          r_a[r_cnt[3:0]] <= in_data;
              if (r_cnt == 5'd31) begin
                r_cnt <= '0;
                if (!in_last) r_err <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 5'd1;
              end
            end
          end
        end
        WAIT_RES: begin
          if (mm_valid_res) begin
            r_res <= {cC4, cC3, cC2, cC1};
            r_idx <= '0;
          end
        end
        DRAIN: begin
          if (out_ready) r_idx <= r_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_4x4_stream_bridge.sv
// Self-checking bench for matrix_4x4_stream_bridge with a behavioural engine model
// and a scoreboard of expected result words.
module tb_matrix_4x4_stream_bridge;

  localparam int W = 12;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_last = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           out_ready = 1'b0;
  logic           mmReadyGate = 1'b1;
  logic           in_ready, out_valid, out_last, err, mm_valid, mm_ready_res;
  logic [W-1:0]   out_data;
  logic           mm_ready;
  logic           mm_valid_res = 1'b0;
  logic [4*W-1:0] aC1, aC2, aC3, aC4, bC1, bC2, bC3, bC4;
  logic [4*W-1:0] cC1 = '0, cC2 = '0, cC3 = '0, cC4 = '0;

  int nCompared = 0;
  int nMismatched = 0;

  logic [W-1:0] stim [32];
  logic [W-1:0] expQ [$];
  logic [W:0]   obsQ [$];

  int engState = 0;
  int engCnt = 0;
  int issues = 0;
  int captures = 0;

  matrix_4x4_stream_bridge #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err(err),
    .mm_valid(mm_valid), .mm_ready(mm_ready), .mm_ready_res(mm_ready_res), .mm_valid_res(mm_valid_res),
    .aC1(aC1), .aC2(aC2), .aC3(aC3), .aC4(aC4),
    .bC1(bC1), .bC2(bC2), .bC3(bC3), .bC4(bC4),
    .cC1(cC1), .cC2(cC2), .cC3(cC3), .cC4(cC4)
  );

  always #5 clk = ~clk;

  // Engine model: reads operand buses at the end of its compute time
  function automatic logic [W-1:0] busA(int r, int c);
    logic [4*W-1:0] v;
    case (c)
      0: v = aC1;
      1: v = aC2;
      2: v = aC3;
      default: v = aC4;
    endcase
    return v[r*W +: W];
  endfunction

  function automatic logic [W-1:0] busB(int r, int c);
    logic [4*W-1:0] v;
    case (c)
      0: v = bC1;
      1: v = bC2;
      2: v = bC3;
      default: v = bC4;
    endcase
    return v[r*W +: W];
  endfunction

  function automatic logic [4*W-1:0] engCol(int c);
    logic [4*W-1:0] v;
    logic [W-1:0]   s;
    v = '0;
    for (int r = 0; r < 4; r++) begin
      s = '0;
      for (int k = 0; k < 4; k++) s = s + busA(r, k) * busB(k, c);
      v[r*W +: W] = s;
    end
    return v;
  endfunction

  assign mm_ready = mmReadyGate && (engState == 0);

  // Valid stays up one cycle past the result handshake, with garbage columns on that cycle
  always @(posedge clk) begin
    case (engState)
      0: if (mm_valid && mm_ready) begin
        engState <= 1;
        engCnt   <= 3;
        issues   <= issues + 1;
      end
      1: if (engCnt == 0) begin
        cC1 <= engCol(0);
        cC2 <= engCol(1);
        cC3 <= engCol(2);
        cC4 <= engCol(3);
        mm_valid_res <= 1'b1;
        engState <= 2;
      end else begin
        engCnt <= engCnt - 1;
      end
      2: if (mm_ready_res) begin
        captures <= captures + 1;
        cC1 <= {4{12'hA5A}};
        cC2 <= {4{12'h5A5}};
        cC3 <= {4{12'hFFF}};
        cC4 <= {4{12'h123}};
        engState <= 3;
      end
      default: begin
        mm_valid_res <= 1'b0;
        engState <= 0;
      end
    endcase
  end

  function automatic logic [4*W-1:0] stimCol(int base);
    return {stim[base+3], stim[base+2], stim[base+1], stim[base]};
  endfunction

  task automatic pushExpected();
    logic [W-1:0] s;
    for (int n = 0; n < 16; n++) begin
      s = '0;
      for (int k = 0; k < 4; k++) s = s + stim[k*4 + n%4] * stim[16 + (n/4)*4 + k];
      expQ.push_back(s);
    end
  endtask

  task automatic fillRandom();
    for (int k = 0; k < 32; k++) stim[k] = W'($urandom_range(0, 4095));
  endtask

  task automatic sendJob(input int nWords, input int lastPos);
    int t;
    for (int k = 0; k < nWords; k++) begin
      in_valid = 1'b1;
      in_data  = stim[k];
      in_last  = (k == lastPos);
      t = 0;
      while (!in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (t >= 300) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL send_timeout: word %0d not accepted, in_ready=%b want 1", k, in_ready);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect(input int maxWords);
    int t;
    int got;
    t = 0;
    got = 0;
    obsQ.delete();
    out_ready = 1'b1;
    while (got < maxWords && t < 500) begin
      if (out_valid) begin
        obsQ.push_back({out_last, out_data});
        got++;
      end
      @(negedge clk);
      t++;
    end
    out_ready = 1'b0;
    if (got < maxWords) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL collect_timeout: got %0d words want %0d", got, maxWords);
    end
  endtask

  task automatic popPair(output logic [W-1:0] e, output logic [W:0] o);
    e = expQ.pop_front();
    o = obsQ.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nCompared++;
    if ({in_ready, out_valid, out_last, err, mm_valid, mm_ready_res} !== 6'b100000) begin
      nMismatched++;
      $display("[TB] FAIL reset_ctrl: got %b want 100000", {in_ready, out_valid, out_last, err, mm_valid, mm_ready_res});
    end
    nCompared++;
    if (out_data !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_out_data: got %h want 0", out_data);
    end
    nCompared++;
    if ({aC1, aC2, aC3, aC4, bC1, bC2, bC3, bC4} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_operands: got nonzero want 0");
    end
    rst_n = 1'b1;
    @(negedge clk);
    nCompared++;
    if ({in_ready, out_valid, mm_valid} !== 3'b100) begin
      nMismatched++;
      $display("[TB] FAIL reset_idle: got %b want 100", {in_ready, out_valid, mm_valid});
    end
  endtask

  task automatic test_identity();
    logic [W-1:0] e;
    logic [W:0]   o;
    int i;
    for (int k = 0; k < 16; k++) stim[k] = ((k / 4) == (k % 4)) ? W'(1) : W'(0);
    for (int k = 0; k < 16; k++) stim[16+k] = W'(k + 1);
    pushExpected();
    sendJob(32, 31);
    collect(16);
    nCompared++;
    if (obsQ.size() != 16) begin
      nMismatched++;
      $display("[TB] FAIL identity_count: got %0d want 16", obsQ.size());
    end
    i = 0;
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      popPair(e, o);
      nCompared++;
      if (o[W-1:0] !== e || e !== W'(i + 1)) begin
        nMismatched++;
        $display("[TB] FAIL identity_data[%0d]: got %0d want %0d", i, o[W-1:0], i + 1);
      end
      nCompared++;
      if (o[W] !== (i == 15)) begin
        nMismatched++;
        $display("[TB] FAIL identity_last[%0d]: got %b want %b", i, o[W], (i == 15));
      end
      i++;
    end
    expQ.delete();
    nCompared++;
    if (err !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL identity_err: got %b want 0", err);
    end
  endtask

  task automatic test_stability();
    logic [W-1:0] e;
    logic [W:0]   o;
    int t;
    int i;
    for (int k = 0; k < 16; k++) stim[k] = W'(2);
    for (int k = 16; k < 32; k++) stim[k] = W'(3);
    pushExpected();
    sendJob(32, 31);
    t = 0;
    while (!out_valid && t < 300) begin
      if (mm_valid || mm_ready_res) begin
        nCompared++;
        if ({aC4, aC3, aC2, aC1} !== {stimCol(12), stimCol(8), stimCol(4), stimCol(0)}) begin
          nMismatched++;
          $display("[TB] FAIL stable_a: got %h want %h", {aC4, aC3, aC2, aC1}, {stimCol(12), stimCol(8), stimCol(4), stimCol(0)});
        end
        nCompared++;
        if ({bC4, bC3, bC2, bC1} !== {stimCol(28), stimCol(24), stimCol(20), stimCol(16)}) begin
          nMismatched++;
          $display("[TB] FAIL stable_b: got %h want %h", {bC4, bC3, bC2, bC1}, {stimCol(28), stimCol(24), stimCol(20), stimCol(16)});
        end
      end
      @(negedge clk);
      t++;
    end
    collect(16);
    i = 0;
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      popPair(e, o);
      nCompared++;
      if (o[W-1:0] !== W'(24)) begin
        nMismatched++;
        $display("[TB] FAIL all24_data[%0d]: got %0d want 24 (model %0d)", i, o[W-1:0], e);
      end
      i++;
    end
    nCompared++;
    if (i != 16) begin
      nMismatched++;
      $display("[TB] FAIL all24_count: got %0d want 16", i);
    end
    expQ.delete();
  endtask

  task automatic test_back_to_back_stall();
    logic [W-1:0] e;
    logic [W:0]   o;
    logic [W-1:0] held;
    logic         heldValid;
    int t;
    int got;
    int i;
    fillRandom();
    pushExpected();
    sendJob(32, 31);
    t = 0;
    while (!out_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    obsQ.delete();
    t = 0;
    got = 0;
    heldValid = 1'b0;
    held = '0;
    while (got < 16 && t < 300) begin
      out_ready = (t % 2 == 1);
      if (heldValid) begin
        nCompared++;
        if (out_data !== held) begin
          nMismatched++;
          $display("[TB] FAIL stall_hold: got %h want %h", out_data, held);
        end
      end
      heldValid = 1'b0;
      nCompared++;
      if (in_ready !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL stall_in_ready: got %b want 0 at transfer %0d", in_ready, got);
      end
      if (out_valid && out_ready) begin
        obsQ.push_back({out_last, out_data});
        got++;
      end else if (out_valid) begin
        held = out_data;
        heldValid = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    out_ready = 1'b0;
    nCompared++;
    if (got != 16) begin
      nMismatched++;
      $display("[TB] FAIL stall_count: got %0d want 16", got);
    end
    nCompared++;
    if ({in_ready, out_valid} !== 2'b10) begin
      nMismatched++;
      $display("[TB] FAIL stall_release: got %b want 10", {in_ready, out_valid});
    end
    i = 0;
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      popPair(e, o);
      nCompared++;
      if (o[W-1:0] !== e) begin
        nMismatched++;
        $display("[TB] FAIL stall_data[%0d]: got %h want %h", i, o[W-1:0], e);
      end
      i++;
    end
    expQ.delete();
  endtask

  task automatic test_framing();
    logic [W-1:0] e;
    logic [W:0]   o;
    int i;
    fillRandom();
    sendJob(6, 5);
    nCompared++;
    if ({err, in_ready, mm_valid} !== 3'b110) begin
      nMismatched++;
      $display("[TB] FAIL framing_abort: got %b want 110", {err, in_ready, mm_valid});
    end
    fillRandom();
    pushExpected();
    sendJob(32, 31);
    collect(16);
    i = 0;
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      popPair(e, o);
      nCompared++;
      if (o[W-1:0] !== e) begin
        nMismatched++;
        $display("[TB] FAIL framing_data[%0d]: got %h want %h", i, o[W-1:0], e);
      end
      i++;
    end
    nCompared++;
    if (i != 16) begin
      nMismatched++;
      $display("[TB] FAIL framing_count: got %0d want 16", i);
    end
    expQ.delete();
    nCompared++;
    if (err !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL framing_sticky: got %b want 1", err);
    end
  endtask

  task automatic test_issue_stall();
    logic [W-1:0] e;
    logic [W:0]   o;
    int issues0;
    int captures0;
    int i;
    mmReadyGate = 1'b0;
    issues0 = issues;
    captures0 = captures;
    fillRandom();
    pushExpected();
    sendJob(32, 31);
    for (int c = 0; c < 10; c++) begin
      nCompared++;
      if (mm_valid !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL issue_hold[%0d]: got %b want 1", c, mm_valid);
      end
      @(negedge clk);
    end
    mmReadyGate = 1'b1;
    collect(16);
    i = 0;
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      popPair(e, o);
      nCompared++;
      if (o[W-1:0] !== e) begin
        nMismatched++;
        $display("[TB] FAIL issue_data[%0d]: got %h want %h", i, o[W-1:0], e);
      end
      i++;
    end
    expQ.delete();
    nCompared++;
    if (issues - issues0 != 1 || captures - captures0 != 1) begin
      nMismatched++;
      $display("[TB] FAIL issue_once: got issues %0d captures %0d want 1 1", issues - issues0, captures - captures0);
    end
    nCompared++;
    if (mm_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL issue_idle: got %b want 0", mm_valid);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [W-1:0] e;
    logic [W:0]   o;
    int i;
    fillRandom();
    pushExpected();
    sendJob(32, 31);
    collect(7);
    i = 0;
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      popPair(e, o);
      nCompared++;
      if (o[W-1:0] !== e) begin
        nMismatched++;
        $display("[TB] FAIL middrain_data[%0d]: got %h want %h", i, o[W-1:0], e);
      end
      i++;
    end
    expQ.delete();
    rst_n = 1'b0;
    @(negedge clk);
    nCompared++;
    if ({out_valid, in_ready, err, mm_valid} !== 4'b0100) begin
      nMismatched++;
      $display("[TB] FAIL middrain_reset: got %b want 0100", {out_valid, in_ready, err, mm_valid});
    end
    rst_n = 1'b1;
    @(negedge clk);
    fillRandom();
    pushExpected();
    sendJob(32, 31);
    collect(16);
    i = 0;
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      popPair(e, o);
      nCompared++;
      if (o[W-1:0] !== e) begin
        nMismatched++;
        $display("[TB] FAIL after_reset_data[%0d]: got %h want %h", i, o[W-1:0], e);
      end
      nCompared++;
      if (o[W] !== (i == 15)) begin
        nMismatched++;
        $display("[TB] FAIL after_reset_last[%0d]: got %b want %b", i, o[W], (i == 15));
      end
      i++;
    end
    nCompared++;
    if (i != 16 || err !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL after_reset_job: got %0d words err %b want 16 words err 0", i, err);
    end
    expQ.delete();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_identity();
    test_stability();
    test_back_to_back_stall();
    test_framing();
    test_issue_stall();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
